// File: rtl/temp_out_pkg.sv
// Shared types and constants for the accumulating temporary output buffer.
// The saturation helper clamps a one-bit-wider sum back into an accumulator entry.
package temp_out_pkg;

  localparam int FEATURE_BITS = 4;
  localparam int DATA_W       = 16;
  localparam int ACC_W        = 24;
  localparam int ADDR_W       = 2 * FEATURE_BITS;
  localparam int DEPTH        = 2 ** ADDR_W;

  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] value);
    if (value > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
    else if (value < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
    else                      sat_acc = value[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/temp_out_ram.sv
// Simple dual-port accumulator storage: one write port, one registered read port.
// A read that collides with a write to the same entry returns the previous contents.
module temp_out_ram
  import temp_out_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = ACC_W
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/temp_out_acc_buff.sv
// Accumulates signed partial sums per address, then drains every entry in order
// over a valid/ready stream once the address generator reports the tile is done.
module temp_out_acc_buff
  import temp_out_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic              first_pass,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ag_done,
  input  logic              drain_ready,
  output logic              drain_valid,
  output logic [ACC_W-1:0]  drain_data,
  output logic [ADDR_W-1:0] drain_addr,
  output logic              drain_done,
  output logic              busy
);

  state_t state, state_next;

  logic              s1_valid, s1_first;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic              s2_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic [ACC_W-1:0]  s2_result;

  logic [ACC_W-1:0]  ram_rdata, old_value, new_value, data_ext;
  logic [ACC_W:0]    sum_ext;
  logic [ADDR_W-1:0] ram_raddr;

  logic [ADDR_W-1:0] rd_ptr, pf_addr;
  logic              issued_all, pf_valid;
  logic              accept, out_load, issue, last_handshake;

  assign accept         = wr_en && (state == ACCUM);
  assign last_handshake = drain_valid && drain_ready && (drain_addr == {ADDR_W{1'b1}});
  assign out_load       = pf_valid && (!drain_valid || drain_ready);
  assign issue          = (state == DRAIN) && !issued_all && (!pf_valid || out_load);
  assign busy           = (state != IDLE);
  assign drain_done     = (state == DONE);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // S2 has already committed to memory when its register loads, so only S1 gates the flush.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)          state_next = ACCUM;
      ACCUM:   if (ag_done)        state_next = FLUSH;
      FLUSH:   if (!s1_valid)      state_next = DRAIN;
      DRAIN:   if (last_handshake) state_next = DONE;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_result <= '0;
    end else begin
      s1_valid  <= accept;
      s1_first  <= first_pass;
      s1_addr   <= address;
      s1_data   <= wr_data;
      s2_valid  <= s1_valid;
      s2_addr   <= s1_addr;
      s2_result <= new_value;
    end
  end

  // The memory read for S1 raced the previous write, so take that result directly.
  always_comb begin
    old_value = (s2_valid && (s2_addr == s1_addr)) ? s2_result : ram_rdata;
    data_ext  = {{(ACC_W-DATA_W){s1_data[DATA_W-1]}}, s1_data};
    sum_ext   = {old_value[ACC_W-1], old_value} + {data_ext[ACC_W-1], data_ext};
    new_value = s1_first ? data_ext : sat_acc(sum_ext);
  end

  // While the output is stalled, keep re-reading the prefetched entry so its data survives.
  always_comb begin
    if (state == ACCUM)             ram_raddr = address;
    else if (pf_valid && !out_load) ram_raddr = pf_addr;
    else                            ram_raddr = rd_ptr;
  end

  temp_out_ram #(
    .AW (ADDR_W),
    .DW (ACC_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (s1_valid),
    .waddr   (s1_addr),
    .wdata   (new_value),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      issued_all  <= 1'b0;
      pf_valid    <= 1'b0;
      pf_addr     <= '0;
      drain_valid <= 1'b0;
      drain_data  <= '0;
      drain_addr  <= '0;
    end else if (state != DRAIN) begin
      rd_ptr      <= '0;
      issued_all  <= 1'b0;
      pf_valid    <= 1'b0;
      drain_valid <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        pf_addr <= rd_ptr;
        if (rd_ptr == {ADDR_W{1'b1}}) issued_all <= 1'b1;
      end
      if (issue)         pf_valid <= 1'b1;
      else if (out_load) pf_valid <= 1'b0;
      if (out_load) begin
        drain_valid <= 1'b1;
        drain_data  <= ram_rdata;
        drain_addr  <= pf_addr;
      end else if (drain_ready) begin
        drain_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temp_out_acc_buff.sv
// Randomized self-checking bench for temp_out_acc_buff, using an array model of
// the accumulator contents and checking every drained word and stall behaviour.
module tb_temp_out_acc_buff;
  import temp_out_pkg::*;

  localparam longint SAT_MAX = longint'(2 ** (ACC_W - 1)) - 1;
  localparam longint SAT_MIN = -longint'(2 ** (ACC_W - 1));

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              wr_en = 1'b0;
  logic              first_pass = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ag_done = 1'b0;
  logic              drain_ready = 1'b0;
  logic              drain_valid;
  logic [ACC_W-1:0]  drain_data;
  logic [ADDR_W-1:0] drain_addr;
  logic              drain_done;
  logic              busy;

  int     assert_count = 0;
  int     fail_count = 0;
  longint model [DEPTH];
  longint dut_seen [DEPTH];
  bit     accum_phase = 1'b0;

  temp_out_acc_buff dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .start       (start),
    .wr_en       (wr_en),
    .first_pass  (first_pass),
    .address     (address),
    .wr_data     (wr_data),
    .ag_done     (ag_done),
    .drain_ready (drain_ready),
    .drain_valid (drain_valid),
    .drain_data  (drain_data),
    .drain_addr  (drain_addr),
    .drain_done  (drain_done),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assert_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelWrite(input bit fp, input int addr, input longint data);
    logic [DATA_W-1:0] raw;
    longint value, sum;
    raw   = data[DATA_W-1:0];
    value = longint'($signed(raw));
    if (fp) begin
      model[addr] = value;
    end else begin
      sum = model[addr] + value;
      if (sum > SAT_MAX) sum = SAT_MAX;
      if (sum < SAT_MIN) sum = SAT_MIN;
      model[addr] = sum;
    end
  endfunction

  // Drive one cycle of write-side inputs; the model only sees writes made inside a tile.
  task automatic applyStimulus(input bit we, input bit fp, input int addr, input longint data, input bit done);
    wr_en      = we;
    first_pass = fp;
    address    = addr[ADDR_W-1:0];
    wr_data    = data[DATA_W-1:0];
    ag_done    = done;
    if (we && accum_phase) modelWrite(fp, addr, data);
    if (done) accum_phase = 1'b0;
    @(posedge sys_clk); #1;
    wr_en      = 1'b0;
    first_pass = 1'b0;
    ag_done    = 1'b0;
  endtask

  task automatic startTile();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    accum_phase = 1'b1;
    checkOutput("busy_after_start", busy, 1);
  endtask

  // ready_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random; stop_after>0 quits early.
  task automatic drainTile(input int ready_mode, input int stop_after, input bit junk, output int got);
    logic [3:0]        toggle_pat;
    logic [ACC_W-1:0]  held_data;
    logic [ADDR_W-1:0] held_addr;
    bit                hold;
    int                cycles;
    toggle_pat = 4'b1001;
    hold = 1'b0;
    cycles = 0;
    got = 0;
    held_data = '0;
    held_addr = '0;
    for (int i = 0; i < DEPTH; i++) dut_seen[i] = -1;
    while (got < DEPTH && cycles < 4000 && !(stop_after > 0 && got >= stop_after)) begin
      case (ready_mode)
        0:       drain_ready = 1'b1;
        1:       drain_ready = toggle_pat[cycles % 4];
        default: drain_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        wr_en      = 1'($urandom_range(0, 1));
        first_pass = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
        address    = ADDR_W'($urandom);
        wr_data    = DATA_W'($urandom);
      end
      @(negedge sys_clk);
      if (hold) begin
        checkOutput("hold_valid", drain_valid, 1);
        checkOutput("hold_addr", drain_addr, held_addr);
        checkOutput("hold_data", drain_data, held_data);
      end
      if (drain_valid && drain_ready) begin
        checkOutput("drain_addr", drain_addr, got);
        checkOutput("drain_data", longint'($signed(drain_data)), model[got]);
        dut_seen[got] = longint'($signed(drain_data));
        got++;
      end
      hold      = drain_valid && !drain_ready;
      held_data = drain_data;
      held_addr = drain_addr;
      @(posedge sys_clk); #1;
      cycles++;
    end
    wr_en       = 1'b0;
    first_pass  = 1'b0;
    start       = 1'b0;
    drain_ready = 1'b0;
  endtask

  task automatic fullDrain(input int ready_mode, input bit junk);
    int got;
    drainTile(ready_mode, 0, junk, got);
    checkOutput("drain_count", got, DEPTH);
    checkOutput("drain_done_pulse", drain_done, 1);
    checkOutput("busy_in_done", busy, 1);
    @(posedge sys_clk); #1;
    checkOutput("drain_done_clear", drain_done, 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  task automatic randomAccumulate(input int count);
    int a, prev;
    bit we;
    prev = 0;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 1) == 1 && i > 0) begin
        a = prev;
      end else begin
        do a = int'($urandom_range(0, DEPTH - 1)); while (a == 3 || a == 5 || a == 7 || a == 8);
      end
      prev = a;
      we = ($urandom_range(0, 4) != 0);
      applyStimulus(we, $urandom_range(0, 9) == 0, a, longint'($urandom_range(0, 65535)), 1'b0);
    end
  endtask

  initial begin
    int got;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_drain_valid", drain_valid, 0);
    checkOutput("reset_drain_data", drain_data, 0);
    checkOutput("reset_drain_addr", drain_addr, 0);
    checkOutput("reset_drain_done", drain_done, 0);
    checkOutput("reset_busy", busy, 0);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    applyStimulus(1'b1, 1'b1, 9, 123, 1'b0);
    checkOutput("idle_write_ignored_busy", busy, 0);

    // Tile 1: identity load, drain at full rate.
    startTile();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b1, k, longint'(k), 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    fullDrain(0, 1'b0);
    checkOutput("identity_entry_0", dut_seen[0], 0);
    checkOutput("identity_entry_200", dut_seen[200], 200);
    checkOutput("identity_entry_255", dut_seen[255], 255);

    // Tile 2: forwarding, saturation, random accumulation, write in the ag_done cycle.
    startTile();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b1, k, longint'($urandom_range(0, 65535)), 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 10, 1'b0);
    applyStimulus(1'b1, 1'b0, 5, 7, 1'b0);
    applyStimulus(1'b1, 1'b0, 5, -3, 1'b0);
    applyStimulus(1'b1, 1'b1, 7, 'h7FFF, 1'b0);
    repeat (300) applyStimulus(1'b1, 1'b0, 7, 'h7FFF, 1'b0);
    applyStimulus(1'b1, 1'b1, 8, -32768, 1'b0);
    repeat (300) applyStimulus(1'b1, 1'b0, 8, -32768, 1'b0);
    randomAccumulate(400);
    applyStimulus(1'b1, 1'b1, 3, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3, 4, 1'b1);
    fullDrain(1, 1'b1);
    checkOutput("forward_entry_5", dut_seen[5], 14);
    checkOutput("ag_done_entry_3", dut_seen[3], 5);
    checkOutput("sat_pos_entry_7", dut_seen[7], SAT_MAX);
    checkOutput("sat_neg_entry_8", dut_seen[8], SAT_MIN);

    // Tile 3: reset in the middle of the drain.
    startTile();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b1, k, longint'($urandom_range(0, 65535)), 1'b0);
    randomAccumulate(200);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    drainTile(2, 100, 1'b0, got);
    checkOutput("mid_drain_count", got, 100);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_drain_valid", drain_valid, 0);
    checkOutput("mid_reset_busy", busy, 0);
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // Tile 4: a clean tile after the reset.
    startTile();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b1, k, longint'($urandom_range(0, 65535)), 1'b0);
    randomAccumulate(300);
    applyStimulus(1'b1, 1'b0, int'($urandom_range(10, DEPTH - 1)), longint'($urandom_range(0, 65535)), 1'b1);
    fullDrain(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
